// File: rtl/and3_sweep_ctrl.sv
// Exhaustive 3-input gate tester: walks patterns 0..7 onto a/b/c, lets each settle,
// compares the gate's response against the selected reference function and reports.
module and3_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] gate_sel,
    input  logic       y_in,
    output logic       a_out,
    output logic       b_out,
    output logic       c_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_count,
    output logic [7:0] fail_vec
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_APPLY = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    logic [1:0] state;
    logic [2:0] idx;
    logic [3:0] settle_cnt;
    logic [1:0] sel_q;
    logic       expected_y;
    logic       mismatch;
    logic       last_pattern;

    // Reference response for the latched function; pattern bit 0 is a, bit 2 is c.
    function automatic logic gate_eval(input logic [1:0] sel, input logic [2:0] pat);
        logic r;
        case (sel)
            2'b00:   r = &pat;
            2'b01:   r = |pat;
            2'b10:   r = ^pat;
            default: r = ~(&pat);
        endcase
        return r;
    endfunction

    always_comb begin
        expected_y   = gate_eval(sel_q, idx);
        mismatch     = (y_in != expected_y);
        last_pattern = (idx == 3'd7);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= 3'd0;
            settle_cnt <= 4'd0;
            sel_q      <= 2'b00;
            pass       <= 1'b0;
            fail_count <= 4'd0;
            fail_vec   <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_APPLY;
                        idx        <= 3'd0;
                        settle_cnt <= 4'd0;
                        sel_q      <= gate_sel;
                        pass       <= 1'b0;
                        fail_count <= 4'd0;
                        fail_vec   <= 8'h00;
                    end
                end
                ST_APPLY: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state      <= ST_CHECK;
                        settle_cnt <= 4'd0;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        fail_vec[idx] <= 1'b1;
                        fail_count    <= fail_count + 4'd1;
                    end
                    // pass must include this final pattern's outcome, not just the count so far
                    if (last_pattern) begin
                        state <= ST_DONE;
                        pass  <= (fail_count == 4'd0) && !mismatch;
                    end else begin
                        state <= ST_APPLY;
                        idx   <= idx + 3'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy  = (state == ST_APPLY) || (state == ST_CHECK);
        done  = (state == ST_DONE);
        a_out = busy & idx[0];
        b_out = busy & idx[1];
        c_out = busy & idx[2];
    end

endmodule

// File: tb/tb_and3_sweep_ctrl.sv
// Bench for and3_sweep_ctrl: two instances (settle 1 and 3) driving a behavioural gate model,
// sweep results predicted per vector and checked through a scoreboard when done fires.
module tb_and3_sweep_ctrl;

    typedef struct {
        logic [1:0] sel;
        logic [1:0] msel;
        int         mode;       // 0 correct model, 1 stuck-at-0, 2 stuck-at-1
        bit         mid_switch;
        bit         repulse;
        logic [3:0] fc;
        logic [7:0] fv;
        logic       pass;
    } vec_t;

    typedef struct {
        logic [3:0] fc;
        logic [7:0] fv;
        logic       pass;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_s[2];
    logic       y_s[2];
    logic [1:0] gate_sel_s[2];
    logic [1:0] model_sel[2];
    int         mode_s[2];
    logic       a_s[2], b_s[2], c_s[2], busy_s[2], done_s[2], pass_s[2];
    logic [3:0] fc_s[2];
    logic [7:0] fv_s[2];

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    vec_t vecs[9];

    always #5 clk = ~clk;

    function automatic logic gate_model(input int mode, input logic [1:0] sel,
                                        input logic a, input logic b, input logic c);
        logic r;
        if (mode == 1) return 1'b0;
        if (mode == 2) return 1'b1;
        case (sel)
            2'b00:   r = a & b & c;
            2'b01:   r = a | b | c;
            2'b10:   r = a ^ b ^ c;
            default: r = !(a & b & c);
        endcase
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < 2; i++)
            y_s[i] = gate_model(mode_s[i], model_sel[i], a_s[i], b_s[i], c_s[i]);
    end

    and3_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .gate_sel(gate_sel_s[0]), .y_in(y_s[0]),
        .a_out(a_s[0]), .b_out(b_s[0]), .c_out(c_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .pass(pass_s[0]), .fail_count(fc_s[0]), .fail_vec(fv_s[0])
    );

    and3_sweep_ctrl #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .gate_sel(gate_sel_s[1]), .y_in(y_s[1]),
        .a_out(a_s[1]), .b_out(b_s[1]), .c_out(c_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .pass(pass_s[1]), .fail_count(fc_s[1]), .fail_vec(fv_s[1])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] out_bits(input int w);
        return 32'({a_s[w], b_s[w], c_s[w], busy_s[w], done_s[w], pass_s[w], fc_s[w], fv_s[w]});
    endfunction

    task automatic run_sweep(input string name, input int w, input vec_t v);
        int         s, cyc, done_cnt, first_done, pat_err, last_cyc;
        logic [3:0] got_fc;
        logic [7:0] got_fv;
        logic       got_pass;
        exp_t       e;
        s = (w == 1) ? 3 : 1;
        last_cyc = 8 * (s + 1) + 4;
        done_cnt = 0; first_done = 0; pat_err = 0;
        got_fc = 4'hx; got_fv = 8'hxx; got_pass = 1'bx;
        @(negedge clk);
        gate_sel_s[w] = v.sel;
        model_sel[w]  = v.msel;
        mode_s[w]     = v.mode;
        start_s[w]    = 1'b1;
        sb_q.push_back('{v.fc, v.fv, v.pass, 8 * (s + 1) + 1});
        @(negedge clk);
        start_s[w] = 1'b0;
        cyc = 1;
        while (cyc <= last_cyc) begin
            if ((cyc <= 8 * (s + 1)) != busy_s[w]) pat_err++;
            if (busy_s[w]) begin
                if (32'({c_s[w], b_s[w], a_s[w]}) != 32'((cyc - 1) / (s + 1))) pat_err++;
            end else if (a_s[w] | b_s[w] | c_s[w]) begin
                pat_err++;
            end
            if (done_s[w]) begin
                done_cnt++;
                if (first_done == 0) first_done = cyc;
                got_fc = fc_s[w]; got_fv = fv_s[w]; got_pass = pass_s[w];
            end
            if (v.repulse && cyc == 3) start_s[w] = 1'b1;
            if (v.repulse && cyc == 4) start_s[w] = 1'b0;
            if (v.mid_switch && cyc == 5) gate_sel_s[w] = 2'b00;
            @(negedge clk);
            cyc++;
        end
        if (sb_q.size() == 0) begin
            check({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({name, "_latency"}, 32'(first_done), 32'(e.lat));
            check({name, "_done_count"}, 32'(done_cnt), 32'd1);
            check({name, "_fail_count"}, 32'(got_fc), 32'(e.fc));
            check({name, "_fail_vec"}, 32'(got_fv), 32'(e.fv));
            check({name, "_pass"}, 32'(got_pass), 32'(e.pass));
            check({name, "_held"}, 32'({pass_s[w], fc_s[w], fv_s[w]}), 32'({e.pass, e.fc, e.fv}));
        end
        check({name, "_pattern_seq"}, 32'(pat_err), 32'd0);
    endtask

    initial begin
        int   seen_done;
        vec_t v;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0; gate_sel_s[i] = 2'b00; model_sel[i] = 2'b00; mode_s[i] = 0;
        end

        // sel, model sel, mode, mid switch, repulse, fail_count, fail_vec, pass
        vecs[0] = '{2'b00, 2'b00, 0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1};
        vecs[1] = '{2'b00, 2'b00, 1, 1'b0, 1'b0, 4'd1, 8'h80, 1'b0};
        vecs[2] = '{2'b00, 2'b00, 2, 1'b0, 1'b0, 4'd7, 8'h7F, 1'b0};
        vecs[3] = '{2'b01, 2'b01, 0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1};
        vecs[4] = '{2'b11, 2'b11, 0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1};
        vecs[5] = '{2'b10, 2'b10, 0, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1};
        vecs[6] = '{2'b01, 2'b00, 0, 1'b0, 1'b0, 4'd6, 8'h7E, 1'b0};
        vecs[7] = '{2'b10, 2'b00, 1, 1'b0, 1'b0, 4'd4, 8'h96, 1'b0};
        vecs[8] = '{2'b00, 2'b00, 0, 1'b0, 1'b1, 4'd0, 8'h00, 1'b1};

        seen_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_s[0] | done_s[1]) seen_done = 1;
        end
        check("reset_outputs_s1", out_bits(0), 32'd0);
        check("reset_outputs_s3", out_bits(1), 32'd0);
        check("reset_no_done", 32'(seen_done), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_sweep($sformatf("vec%0d", i), 0, vecs[i]);

        // Abort a failing sweep at pattern 4 and make sure nothing of it survives.
        @(negedge clk);
        gate_sel_s[0] = 2'b00; model_sel[0] = 2'b00; mode_s[0] = 2; start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        seen_done = 0;
        repeat (8) begin
            @(negedge clk);
            if (done_s[0]) seen_done = 1;
        end
        check("abort_idx", 32'({c_s[0], b_s[0], a_s[0]}), 32'd4);
        #2 rst_n = 1'b0;
        #1 check("abort_async_outputs", out_bits(0), 32'd0);
        repeat (3) begin
            @(negedge clk);
            if (done_s[0]) seen_done = 1;
        end
        rst_n = 1'b1;
        check("abort_no_done", 32'(seen_done), 32'd0);
        run_sweep("after_abort", 0, vecs[0]);

        v = '{2'b00, 2'b00, 0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1};
        run_sweep("s3_and_ok", 1, v);
        v = '{2'b11, 2'b00, 2, 1'b0, 1'b0, 4'd1, 8'h80, 1'b0};
        run_sweep("s3_nand_stuck1", 1, v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
